// File: rtl/iomem_bus_ctrl.sv
// PicoRV32 iomem bus controller: decodes addr[31:24] to one slave, waits for its
// ready (bounded by a timeout) and returns rdata, or an error response on a miss.
module iomem_bus_ctrl #(
    parameter int unsigned                NUM_SLAVES = 4,
    parameter logic [8*NUM_SLAVES-1:0]    SLAVE_IDS  = 32'h07050403,
    parameter logic [15:0]                TIMEOUT    = 16'd255,
    parameter logic [31:0]                ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [3:0]                 m_wstrb,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic                       err_pulse,
    output logic [7:0]                 err_count,
    output logic [31:0]                err_addr
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERROR  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state_r;
    logic [SEL_W-1:0]  sel_r;
    logic [15:0]       cnt_r;
    logic              hit_s;
    logic [SEL_W-1:0]  hit_idx_s;
    logic              sel_ready_s;
    logic [31:0]       sel_rdata_s;
    logic              timeout_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (m_addr[31:24] == SLAVE_IDS[8*i +: 8]) begin
                hit_s     = 1'b1;
                hit_idx_s = SEL_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Ready/rdata of the selected slave only; all others are ignored.
    always_comb begin
        sel_ready_s = 1'b0;
        sel_rdata_s = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_r == SEL_W'(i)) begin
                sel_ready_s = s_ready[i];
                sel_rdata_s = s_rdata[32*i +: 32];
            end else begin
                sel_ready_s = sel_ready_s;
                sel_rdata_s = sel_rdata_s;
            end
        end
    end

    // Timeout fires on the TIMEOUT-th ACCESS cycle without ready.
    always_comb begin
        if (TIMEOUT != 16'd0) begin
            timeout_s = ((cnt_r + 16'd1) == TIMEOUT);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            sel_r     <= '0;
            cnt_r     <= 16'd0;
            m_ready   <= 1'b0;
            m_rdata   <= 32'd0;
            s_valid   <= '0;
            s_wstrb   <= 4'd0;
            s_addr    <= 32'd0;
            s_wdata   <= 32'd0;
            err_pulse <= 1'b0;
            err_count <= 8'd0;
            err_addr  <= 32'd0;
        end else begin
            m_ready   <= 1'b0;
            err_pulse <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        if (hit_s) begin
                            sel_r   <= hit_idx_s;
                            s_valid <= NUM_SLAVES'(1) << hit_idx_s;
                            state_r <= ACCESS;
                        end else begin
                            state_r <= ERROR;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_ready_s) begin
                        m_rdata <= sel_rdata_s;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        state_r <= RESP;
                    end else if (timeout_s) begin
                        m_rdata   <= ERR_DATA;
                        s_valid   <= '0;
                        m_ready   <= 1'b1;
                        err_pulse <= 1'b1;
                        err_addr  <= s_addr;
                        err_count <= sat_inc(err_count);
                        state_r   <= RESP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ERROR: begin
                    m_rdata   <= ERR_DATA;
                    m_ready   <= 1'b1;
                    err_pulse <= 1'b1;
                    err_addr  <= s_addr;
                    err_count <= sat_inc(err_count);
                    state_r   <= RESP;
                end
                RESP: begin
                    cnt_r   <= 16'd0;
                    state_r <= IDLE;
                end
                default: begin
                    s_valid <= '0;
                    cnt_r   <= 16'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Directed bench for iomem_bus_ctrl: hit, slow slave, miss, timeout, reset abort
// and error-count saturation, with hand-computed expectations.
module tb_iomem_bus_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   m_wstrb;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic [3:0]   s_wstrb;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic         err_pulse;
    logic [7:0]   err_count;
    logic [31:0]  err_addr;

    int compared = 0;
    int mismatched = 0;

    iomem_bus_ctrl #(
        .NUM_SLAVES(4),
        .SLAVE_IDS (32'h07050403),
        .TIMEOUT   (16'd16),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
        .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .err_pulse(err_pulse), .err_count(err_count), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Results of the last transaction.
    int          vcnt, resp, epulses, badsel, badbus;
    logic [31:0] rd;
    logic [31:0] wd_seen;

    // One master transaction. Slave sl answers with rdata on its (delay+1)-th
    // s_valid cycle (delay<0: never). toggle0 wiggles s_ready[0] as a stray.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int sl, input logic [3:0] exp_mask, input int delay,
                       input logic [31:0] rdat, input bit toggle0);
        @(negedge clk);
        m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws; s_ready = 4'd0;
        for (int i = 0; i < 4; i++) s_rdata[32*i +: 32] = 32'hBAD0_0000 | i;
        s_rdata[32*sl +: 32] = rdat;
        vcnt = 0; resp = -1; epulses = 0; badsel = 0; badbus = 0; wd_seen = 32'd0;
        for (int c = 1; c <= 60 && resp < 0; c++) begin
            @(negedge clk);
            s_ready = 4'd0;
            if (toggle0) s_ready[0] = c[0];
            if (err_pulse) epulses++;
            if ((s_valid & ~exp_mask) != 4'd0) badsel++;
            if (s_valid != 4'd0) begin
                vcnt++;
                wd_seen = s_wdata;
                if (s_addr !== a || s_wstrb !== ws) badbus++;
                if (delay >= 0 && vcnt == delay + 1) s_ready[sl] = 1'b1;
            end
            if (m_ready) begin
                resp = c; rd = m_rdata; m_valid = 1'b0; s_ready = 4'd0;
            end
        end
        if (resp < 0) m_valid = 1'b0;
    endtask

    int tot_pulses, tot_bad;

    initial begin
        reset = 1'b1; m_valid = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
        m_wstrb = 4'd0; s_ready = 4'd0; s_rdata = 128'd0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {22'd0, m_ready, err_pulse, s_valid, err_count}, 32'd0);
        check("reset_rdata", m_rdata, 32'd0);
        check("reset_saddr", s_addr, 32'd0);
        reset = 1'b0;

        // Write to gpio, ready on first s_valid cycle.
        txn(32'h0300_0004, 32'h0000_0055, 4'hF, 0, 4'b0001, 0, 32'h0000_0011, 1'b0);
        check("wr_resp_cycle", resp, 32'd2);
        check("wr_valid_cycles", vcnt, 32'd1);
        check("wr_wdata", wd_seen, 32'h0000_0055);
        check("wr_bus_stable", badbus + badsel, 32'd0);
        check("wr_err_pulse", epulses, 32'd0);

        // Read from video, ready 5 cycles after s_valid.
        txn(32'h0500_0010, 32'd0, 4'h0, 2, 4'b0100, 5, 32'h1234_5678, 1'b0);
        check("rd_resp_cycle", resp, 32'd7);
        check("rd_valid_cycles", vcnt, 32'd6);
        check("rd_rdata", rd, 32'h1234_5678);
        check("rd_bus_stable", badbus + badsel, 32'd0);
        @(negedge clk);
        check("rd_rdata_held", m_rdata, 32'h1234_5678);

        // Unmapped read.
        txn(32'h0600_0000, 32'd0, 4'h0, 1, 4'b0000, 0, 32'h0000_0022, 1'b0);
        check("miss_resp_cycle", resp, 32'd2);
        check("miss_no_valid", vcnt, 32'd0);
        check("miss_rdata", rd, 32'hDEAD_BEEF);
        check("miss_pulses", epulses, 32'd1);
        check("miss_err_count", err_count, 32'd1);
        check("miss_err_addr", err_addr, 32'h0600_0000);

        // Timeout on i2c with stray s_ready[0] toggling.
        txn(32'h0700_0000, 32'd0, 4'h0, 3, 4'b1000, -1, 32'h0000_0033, 1'b1);
        check("to_valid_cycles", vcnt, 32'd16);
        check("to_resp_cycle", resp, 32'd17);
        check("to_rdata", rd, 32'hDEAD_BEEF);
        check("to_only_sel", badsel, 32'd0);
        check("to_pulses", epulses, 32'd1);
        check("to_err_count", err_count, 32'd2);
        check("to_err_addr", err_addr, 32'h0700_0000);

        // Reset during ACCESS aborts the transaction.
        @(negedge clk);
        m_valid = 1'b1; m_addr = 32'h0700_0000; m_wstrb = 4'h0; s_ready = 4'd0;
        @(negedge clk);
        check("rst_pre_valid", s_valid, 32'h8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ctrl", {22'd0, m_ready, err_pulse, s_valid, err_count}, 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        reset = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        check("rst_idle", {28'd0, s_valid}, 32'd0);

        // Fresh transaction after reset.
        txn(32'h0400_0008, 32'd0, 4'h0, 1, 4'b0010, 2, 32'hA5A5_0001, 1'b0);
        check("post_rst_resp", resp, 32'd4);
        check("post_rst_rdata", rd, 32'hA5A5_0001);
        check("post_rst_valid", vcnt, 32'd3);

        // 300 misses: err_count saturates at 255.
        tot_pulses = 0; tot_bad = 0;
        for (int i = 0; i < 300; i++) begin
            txn(32'h0000_0000 | (i << 4), 32'd0, 4'h0, 0, 4'b0000, 0, 32'd0, 1'b0);
            tot_pulses += epulses;
            if (resp != 2 || rd !== 32'hDEAD_BEEF) tot_bad++;
            if (i == 9) check("sat_count_10", err_count, 32'd10);
            if (i == 254) check("sat_count_255", err_count, 32'd255);
        end
        check("sat_count_final", err_count, 32'd255);
        check("sat_pulses", tot_pulses, 32'd300);
        check("sat_resp_ok", tot_bad, 32'd0);
        check("sat_err_addr", err_addr, 32'h0000_12B0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
